imem_bus_arbiter: RTL

Parametrised N-channel arbiter that shares the single instruction-side memory bus (REQ/ADDR/BURST/WRB/WDATA/RDATA/ACK/STALL/BSTROBE) among several requesters: I-cache line refill, ITLB page-walk, and future prefetch/debug ports. It succeeds the fixed two-way TLB-over-I-cache mux with:

- registered arbitration, either fixed-priority or round-robin;
- a grant locked across a whole burst;
- per-channel ACK/STALL routing;
- abort on early request withdrawal.

It sits between the requester channels and the external memory interface.

---
 rtl/mem_bus_pkg.sv | 34 +++
 rtl/rr_pick.sv | 39 +++
 rtl/imem_bus_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the instruction-side memory bus arbiters.
// Holds the burst-type encodings, the arbiter state type, and helpers that
// size and load the per-transaction beat counter.
package mem_bus_pkg;

    // Burst type encodings on BURST / burst_i
    localparam logic [1:0] BURST_NORMAL = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;
    localparam logic [1:0] BURST_RSVD   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Beats in one transaction: a full line for INCR/WRAP, otherwise a single beat
    // (the reserved encoding behaves like a normal transfer).
    function automatic int unsigned beat_count(input logic [1:0] burst,
                                               input int unsigned line_beats);
        int unsigned n;
        case (burst)
            BURST_INCR, BURST_WRAP: n = line_beats;
            default:                n = 1;
        endcase
        return n;
    endfunction

    // Counter must hold the value line_beats itself
    function automatic int unsigned cnt_width(input int unsigned line_beats);
        return $clog2(line_beats + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select for a request vector.
// Round-robin mode searches upward from i_ptr and wraps modulo N; fixed mode
// searches upward from index 0, so the lowest requesting index wins.
// Ports:
//   i_req      N-bit request vector
//   i_ptr      round-robin start index (0..N-1)
//   i_rr_mode  1 = round-robin, 0 = fixed priority
//   o_win      one-hot winner, all zero when no request is set
module rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]          i_req,
    input  logic [$clog2(N)-1:0]  i_ptr,
    input  logic                  i_rr_mode,
    output logic [N-1:0]          o_win
);

    localparam int unsigned PTR_W = $clog2(N);

    int               w_off;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // First set request at or after the start index, wrapping around
    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_off   = i_rr_mode ? int'(i_ptr) : 0;
        for (int i = 0; i < int'(N); i++) begin
            w_idx = PTR_W'((w_off + i) % int'(N));
            if (!w_found && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_bus_arbiter.sv
// N-channel arbiter sharing the instruction-side memory bus among requesters
// (I-cache refill, ITLB walk, prefetch, debug).
// A registered grant is chosen in IDLE and held for the whole transaction;
// the master side is a mux of the granted channel driven from that grant.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_i ... bstrobe_i  per-channel request payloads, channel k in slice k
//   grant_o           one-hot registered grant
//   ack_o, stall_o    per-channel ACK / STALL routing
//   rdata_o           read data broadcast to every channel
//   REQ ... BSTROBE   master-side request payload
//   RDATA, ACK, STALL master-side responses
//   busy_o            a transaction is owned
module imem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_BEATS = 8,
    parameter bit          RR_MODE    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [N_REQ-1:0]               req_i,
    input  logic [N_REQ*ADDR_W-1:0]        addr_i,
    input  logic [N_REQ*2-1:0]             burst_i,
    input  logic [N_REQ-1:0]               wrb_i,
    input  logic [N_REQ*DATA_W-1:0]        wdata_i,
    input  logic [N_REQ*(DATA_W/8)-1:0]    bstrobe_i,

    output logic [N_REQ-1:0]               grant_o,
    output logic [N_REQ-1:0]               ack_o,
    output logic [N_REQ-1:0]               stall_o,
    output logic [DATA_W-1:0]              rdata_o,

    output logic                           REQ,
    output logic [ADDR_W-1:0]              ADDR,
    output logic [1:0]                     BURST,
    output logic                           WRB,
    output logic [DATA_W-1:0]              WDATA,
    output logic [DATA_W/8-1:0]            BSTROBE,

    input  logic [DATA_W-1:0]              RDATA,
    input  logic                           ACK,
    input  logic                           STALL,

    output logic                           busy_o
);

    localparam int unsigned PTR_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W  = cnt_width(LINE_BEATS);
    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  w_grant_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;

    logic [N_REQ-1:0]  w_win;
    logic [1:0]        w_win_burst;
    logic [PTR_W-1:0]  w_gidx;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic              w_own;

    // Winner of the current request vector
    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .i_req     (req_i),
        .i_ptr     (r_ptr),
        .i_rr_mode (RR_MODE),
        .o_win     (w_win)
    );

    // Index of the owner and burst type of the prospective winner
    always_comb begin
        w_gidx      = '0;
        w_win_burst = BURST_NORMAL;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (r_grant[k]) begin
                w_gidx = PTR_W'(k);
            end
            if (w_win[k]) begin
                w_win_burst = burst_i[2*k +: 2];
            end
        end
    end

    // Pointer moves one past the channel that just finished or aborted
    assign w_ptr_inc = (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : PTR_W'(w_gidx + 1'b1);

    // Master side follows the granted channel; all zero without a grant
    always_comb begin
        REQ     = 1'b0;
        ADDR    = '0;
        BURST   = BURST_NORMAL;
        WRB     = 1'b0;
        WDATA   = '0;
        BSTROBE = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (r_grant[k]) begin
                REQ     = req_i[k];
                ADDR    = addr_i[k*ADDR_W +: ADDR_W];
                BURST   = burst_i[2*k +: 2];
                WRB     = wrb_i[k];
                WDATA   = wdata_i[k*DATA_W +: DATA_W];
                BSTROBE = bstrobe_i[k*STRB_W +: STRB_W];
            end
        end
    end

    assign w_own   = (r_state == OWN);
    assign grant_o = r_grant;
    assign busy_o  = w_own;
    assign rdata_o = RDATA;
    assign ack_o   = r_grant & {N_REQ{ACK}};

    // Stalls describe contention against an owner, so they are quiet in IDLE
    // (which also keeps them low throughout reset).
    assign stall_o = w_own ? ((r_grant & {N_REQ{STALL}}) | (req_i & ~r_grant)) : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Arbitrate in IDLE, count accepted beats in OWN, abort on withdrawal
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (|req_i) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = w_win;
                    w_cnt_nxt   = CNT_W'(beat_count(w_win_burst, LINE_BEATS));
                end
            end
            OWN: begin
                if (!REQ) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                end else if (ACK) begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_ptr_nxt   = w_ptr_inc;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
